// File: rtl/ts_packet_loss_counter_if.sv
`timescale 1ns/1ps
// TS byte stream into the loss counter plus the QoS control block's clear/readback.
// The master drives the stream and clear; the slave returns the saturating count.
interface ts_packet_loss_counter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   valid;
    logic                   sync;
    logic                   en_reset_counter;
    logic [7:0]             ts_data;
    logic [COUNT_WIDTH-1:0] error_count;

    modport master (
        output valid, sync, en_reset_counter, ts_data,
        input  error_count
    );

    modport slave (
        input  valid, sync, en_reset_counter, ts_data,
        output error_count
    );
endinterface

// File: rtl/ts_packet_loss_counter.sv
`timescale 1ns/1ps
// Purpose: per-PID MPEG-2 TS continuity-counter monitor; counts each CC break (saturating).
// Latency: error_count reflects a packet's check one cycle after its header byte 3 is sampled.
// Backpressure: none; accepts one byte per valid cycle. PLC_DUP_TOLERANCE_EN allows one duplicate CC.
module ts_packet_loss_counter #(
    parameter int NUM_PIDS    = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ts_packet_loss_counter_if.slave  bus
);
    localparam int          IW       = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
    localparam logic [12:0] NULL_PID = 13'h1FFF;
    localparam logic [7:0]  LAST_IDX = 8'd187;

    logic                   r_active;
    logic [7:0]             r_idx;
    logic                   r_tei;
    logic [12:0]            r_pid;
    logic [NUM_PIDS-1:0]    r_tbl_vld;
    logic [12:0]            r_tbl_pid [NUM_PIDS];
    logic [3:0]             r_tbl_cc  [NUM_PIDS];
`ifdef PLC_DUP_TOLERANCE_EN
    logic [NUM_PIDS-1:0]    r_tbl_dup;
    logic                   w_wr_dup;
`endif
    logic [IW-1:0]          r_rr_ptr;
    logic [COUNT_WIDTH-1:0] r_count;

    logic          w_acc;
    logic [7:0]    w_idx;
    logic [3:0]    w_cc;
    logic [1:0]    w_afc;
    logic          w_check;
    logic          w_hit;
    logic [IW-1:0] w_hit_idx;
    logic          w_free;
    logic [IW-1:0] w_free_idx;
    logic [3:0]    w_exp_cc;
    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic          w_err;
    logic          w_rr_adv;

    // r_idx holds the index of the last accepted byte; w_idx is the current byte's index.
    assign w_acc   = bus.valid && !bus.sync && r_active;
    assign w_idx   = r_idx + 8'd1;
    assign w_afc   = bus.ts_data[5:4];
    assign w_cc    = bus.ts_data[3:0];
    assign w_check = w_acc && (w_idx == 8'd3) && !r_tei && (r_pid != NULL_PID) && w_afc[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_idx    <= 8'd0;
            r_tei    <= 1'b0;
            r_pid    <= 13'd0;
        end else if (bus.valid && bus.sync) begin
            r_active <= 1'b1;
            r_idx    <= 8'd0;
        end else if (w_acc) begin
            r_idx <= w_idx;
            if (w_idx == LAST_IDX)
                r_active <= 1'b0;
            if (w_idx == 8'd1) begin
                r_tei        <= bus.ts_data[7];
                r_pid[12:8]  <= bus.ts_data[4:0];
            end
            if (w_idx == 8'd2)
                r_pid[7:0] <= bus.ts_data;
        end
    end

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < NUM_PIDS; i++) begin
            if (r_tbl_vld[i] && (r_tbl_pid[i] == r_pid) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!r_tbl_vld[i] && !w_free) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_exp_cc = r_tbl_cc[w_hit_idx] + 4'd1;
        w_wr_en  = 1'b0;
        w_wr_idx = w_hit_idx;
        w_err    = 1'b0;
        w_rr_adv = 1'b0;
`ifdef PLC_DUP_TOLERANCE_EN
        w_wr_dup = 1'b0;
`endif
        if (w_check) begin
            w_wr_en = 1'b1;
            if (w_hit) begin
                if (w_cc != w_exp_cc) begin
`ifdef PLC_DUP_TOLERANCE_EN
                    // First repeat of the stored CC is a legal retransmission.
                    if ((w_cc == r_tbl_cc[w_hit_idx]) && !r_tbl_dup[w_hit_idx])
                        w_wr_dup = 1'b1;
                    else
                        w_err = 1'b1;
`else
                    w_err = 1'b1;
`endif
                end
            end else if (w_free) begin
                w_wr_idx = w_free_idx;
            end else begin
                w_wr_idx = r_rr_ptr;
                w_rr_adv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tbl_vld <= '0;
            r_rr_ptr  <= '0;
`ifdef PLC_DUP_TOLERANCE_EN
            r_tbl_dup <= '0;
`endif
            for (int i = 0; i < NUM_PIDS; i++) begin
                r_tbl_pid[i] <= 13'd0;
                r_tbl_cc[i]  <= 4'd0;
            end
        end else begin
            if (w_wr_en) begin
                r_tbl_vld[w_wr_idx] <= 1'b1;
                r_tbl_pid[w_wr_idx] <= r_pid;
                r_tbl_cc[w_wr_idx]  <= w_cc;
`ifdef PLC_DUP_TOLERANCE_EN
                r_tbl_dup[w_wr_idx] <= w_wr_dup;
`endif
            end
            if (w_rr_adv)
                r_rr_ptr <= (r_rr_ptr == IW'(NUM_PIDS - 1)) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (bus.en_reset_counter)
            r_count <= '0;
        else if (w_err && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign bus.error_count = r_count;
endmodule

// File: tb/tb_ts_packet_loss_counter.sv
`timescale 1ns/1ps
// Directed bench for ts_packet_loss_counter: table of packets with expected counts,
// followed by hand-built sequences for timing, aborts, saturation, clear and reset.
module tb_ts_packet_loss_counter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ts_packet_loss_counter_if #(.COUNT_WIDTH(8)) bus ();

    ts_packet_loss_counter #(.NUM_PIDS(8), .COUNT_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [12:0] pid;
        logic [1:0]  afc;
        logic        tei;
        logic [3:0]  cc;
        logic        clr;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_c;

`ifdef PLC_DUP_TOLERANCE_EN
    localparam logic [7:0] DUP_A = 8'd2;
    localparam logic [7:0] DUP_B = 8'd3;
`else
    localparam logic [7:0] DUP_A = 8'd3;
    localparam logic [7:0] DUP_B = 8'd4;
`endif

    function automatic void add(input logic [12:0] pid, input logic [1:0] afc, input logic tei,
                                input logic [3:0] cc, input logic clr, input logic [7:0] e);
        vec_t v;
        v.pid = pid; v.afc = afc; v.tei = tei; v.cc = cc; v.clr = clr; v.exp_cnt = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: error_count=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic clr);
        @(negedge clk);
        bus.valid = v;
        bus.sync = s;
        bus.ts_data = d;
        bus.en_reset_counter = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pkt(input logic [12:0] pid, input logic [1:0] afc, input logic tei,
                            input logic [3:0] cc, input logic clr, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 2 == 1))
                drive(1'b0, 1'b0, 8'hFF, 1'b0);
            case (i)
                0:       drive(1'b1, 1'b1, 8'h47, 1'b0);
                1:       drive(1'b1, 1'b0, {tei, 2'b00, pid[12:8]}, 1'b0);
                2:       drive(1'b1, 1'b0, pid[7:0], 1'b0);
                3:       drive(1'b1, 1'b0, {2'b00, afc, cc}, clr);
                default: drive(1'b1, 1'b0, 8'(i), 1'b0);
            endcase
        end
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid = 1'b0;
        bus.sync = 1'b0;
        bus.ts_data = 8'h00;
        bus.en_reset_counter = 1'b0;

        for (int i = 0; i < 20; i++) add(13'h100, 2'b01, 1'b0, 4'(i % 16), 1'b0, 8'd0);
        add(13'h100, 2'b01, 1'b0, 4'd4,  1'b0, 8'd0);
        add(13'h100, 2'b01, 1'b0, 4'd5,  1'b0, 8'd0);
        add(13'h100, 2'b01, 1'b0, 4'd7,  1'b0, 8'd1);
        add(13'h100, 2'b01, 1'b0, 4'd8,  1'b0, 8'd1);
        add(13'h200, 2'b01, 1'b0, 4'd0,  1'b0, 8'd1);
        add(13'h100, 2'b01, 1'b0, 4'd9,  1'b0, 8'd1);
        add(13'h200, 2'b01, 1'b0, 4'd1,  1'b0, 8'd1);
        add(13'h100, 2'b01, 1'b0, 4'd10, 1'b0, 8'd1);
        add(13'h200, 2'b01, 1'b0, 4'd2,  1'b0, 8'd1);
        add(13'h100, 2'b01, 1'b0, 4'd11, 1'b0, 8'd1);
        add(13'h200, 2'b01, 1'b0, 4'd4,  1'b0, 8'd2);
        add(13'h100, 2'b01, 1'b0, 4'd12, 1'b0, 8'd2);
        add(13'h200, 2'b01, 1'b0, 4'd5,  1'b0, 8'd2);
        add(13'h1FFF, 2'b01, 1'b0, 4'd5, 1'b0, 8'd2);
        add(13'h1FFF, 2'b01, 1'b0, 4'd9, 1'b0, 8'd2);
        add(13'h100, 2'b10, 1'b0, 4'd0,  1'b0, 8'd2);
        add(13'h100, 2'b00, 1'b0, 4'd3,  1'b0, 8'd2);
        add(13'h100, 2'b01, 1'b1, 4'd7,  1'b0, 8'd2);
        add(13'h100, 2'b01, 1'b0, 4'd13, 1'b0, 8'd2);
        add(13'h100, 2'b11, 1'b0, 4'd14, 1'b0, 8'd2);
        add(13'h100, 2'b01, 1'b0, 4'd0,  1'b1, 8'd0);
        add(13'h100, 2'b01, 1'b0, 4'd1,  1'b0, 8'd0);
        for (int i = 3; i <= 8; i++) add(13'(i * 256), 2'b01, 1'b0, 4'd0, 1'b0, 8'd0);
        // Table full from here on: 0x900 evicts 0x100, then 0x100 evicts 0x200, and so on.
        add(13'h900, 2'b01, 1'b0, 4'd0,  1'b0, 8'd0);
        add(13'h100, 2'b01, 1'b0, 4'd5,  1'b0, 8'd0);
        add(13'h300, 2'b01, 1'b0, 4'd1,  1'b0, 8'd0);
        add(13'h300, 2'b01, 1'b0, 4'd3,  1'b0, 8'd1);
        add(13'h200, 2'b01, 1'b0, 4'd9,  1'b0, 8'd1);
        add(13'h300, 2'b01, 1'b0, 4'd9,  1'b0, 8'd1);
        add(13'h900, 2'b01, 1'b0, 4'd2,  1'b0, 8'd2);
        add(13'h500, 2'b01, 1'b0, 4'd1,  1'b0, 8'd2);
        add(13'h500, 2'b01, 1'b0, 4'd1,  1'b0, DUP_A);
        add(13'h500, 2'b01, 1'b0, 4'd1,  1'b0, DUP_B);
        add(13'h500, 2'b01, 1'b0, 4'd2,  1'b0, DUP_B);

        repeat (3) @(negedge clk);
        check("reset_state", bus.error_count, 8'd0);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            send_pkt(vecs[k].pid, vecs[k].afc, vecs[k].tei, vecs[k].cc, vecs[k].clr, 5, (k % 3) == 0);
            check($sformatf("vec%0d", k), bus.error_count, vecs[k].exp_cnt);
        end
        exp_c = DUP_B;

        // Byte-3 timing: count must change only after the edge that samples byte 3.
        drive(1'b1, 1'b1, 8'h47, 1'b0);
        drive(1'b1, 1'b0, 8'h06, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h15, 1'b0);
        check("pre_byte3_edge", bus.error_count, exp_c);
        idle();
        exp_c = exp_c + 8'd1;
        check("post_byte3_edge", bus.error_count, exp_c);

        // Sync at index 2 aborts the header; the restarted packet is in order.
        drive(1'b1, 1'b1, 8'h47, 1'b0);
        drive(1'b1, 1'b0, 8'h07, 1'b0);
        idle();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        send_pkt(13'h600, 2'b01, 1'b0, 4'd6, 1'b0, 6, 1'b1);
        check("sync_abort_idx2", bus.error_count, exp_c);

        // Full 188-byte packet, then header-like bytes without sync must be ignored.
        send_pkt(13'h600, 2'b01, 1'b0, 4'd7, 1'b0, 188, 1'b0);
        check("full_packet", bus.error_count, exp_c);
        drive(1'b1, 1'b0, 8'h47, 1'b0);
        drive(1'b1, 1'b0, 8'h06, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h1C, 1'b0);
        idle();
        check("idle_after_187", bus.error_count, exp_c);
        send_pkt(13'h600, 2'b01, 1'b0, 4'd8, 1'b0, 4, 1'b0);
        check("post_idle_in_order", bus.error_count, exp_c);

        // 300 discontinuities on 0x700 (stored CC 0): each step jumps by 2.
        for (int i = 1; i <= 300; i++)
            send_pkt(13'h700, 2'b01, 1'b0, 4'((2 * i) % 16), 1'b0, 4, 1'b0);
        check("saturate", bus.error_count, 8'd255);
        send_pkt(13'h700, 2'b01, 1'b0, 4'd0, 1'b0, 4, 1'b0);
        check("saturate_hold", bus.error_count, 8'd255);
        send_pkt(13'h700, 2'b01, 1'b0, 4'd5, 1'b1, 4, 1'b0);
        check("clear_beats_error", bus.error_count, 8'd0);
        send_pkt(13'h700, 2'b01, 1'b0, 4'd9, 1'b0, 4, 1'b0);
        check("error_after_clear", bus.error_count, 8'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        check("clear_level", bus.error_count, 8'd0);

        // Reset mid-packet forgets the table; first packet per PID afterwards is never counted.
        send_pkt(13'h600, 2'b01, 1'b0, 4'd12, 1'b0, 4, 1'b0);
        check("pre_reset_err", bus.error_count, 8'd1);
        drive(1'b1, 1'b1, 8'h47, 1'b0);
        drive(1'b1, 1'b0, 8'h06, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        bus.valid = 1'b0;
        @(negedge clk);
        check("reset_mid_packet", bus.error_count, 8'd0);
        reset_n = 1'b1;
        send_pkt(13'h600, 2'b01, 1'b0, 4'd3, 1'b0, 4, 1'b0);
        check("first_after_reset", bus.error_count, 8'd0);
        send_pkt(13'h600, 2'b01, 1'b0, 4'd5, 1'b0, 4, 1'b0);
        check("error_after_reset", bus.error_count, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
